// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scanner.
package sevenseg_pkg;

    typedef logic [6:0] seg_pat_t;

    localparam seg_pat_t SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for 0-9 and A,b,C,d,E,F.
    localparam seg_pat_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sevenseg_scan8_if.sv
// Digit data and scan strobe in, active-low display drive out.
interface sevenseg_scan8_if;
    logic        enb;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [6:0]  segs_n;
    logic        dp_n;
    logic [7:0]  an_n;

    modport master (output enb, digits, dp, blank, input segs_n, dp_n, an_n);
    modport slave  (input enb, digits, dp, blank, output segs_n, dp_n, an_n);
endinterface

// File: rtl/sevenseg_dec.sv
// Combinational 4-bit code to active-low segment pattern.
module sevenseg_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] code,
    output seg_pat_t   seg
);
    assign seg = SEG_LUT[code];
endmodule

// File: rtl/sevenseg_scan8.sv
// 8-digit multiplexed seven-segment driver with anti-ghost guard interval.
// Define SSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan8
    import sevenseg_pkg::*;
#(
    parameter int GUARD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    sevenseg_scan8_if.slave  bus
);

    logic [2:0] idx_q, idx_d;
    logic [7:0] gcnt_q, gcnt_d;
    seg_pat_t   segs_n_q, segs_n_d;
    logic       dp_n_q, dp_n_d;
    logic [7:0] an_n_q, an_n_d;

    logic [3:0] code_sel;
    seg_pat_t   seg_pat;
    logic [7:0] lz_blank;
    logic       dark;

    always_comb begin
        idx_d  = idx_q;
        gcnt_d = gcnt_q;
        if (bus.enb) begin
            idx_d  = idx_q + 3'd1;
            gcnt_d = 8'(GUARD_CYC);
        end else if (gcnt_q != 8'd0) begin
            gcnt_d = gcnt_q - 8'd1;
        end
    end

    // Decode off the post-update index so outputs match the state at the same edge.
    assign code_sel = bus.digits[{idx_d, 2'b00} +: 4];

    sevenseg_dec u_dec (
        .code (code_sel),
        .seg  (seg_pat)
    );

`ifdef SSEG_LZB_EN
    // A zero run from the top digit downward; a lit dp ends the run.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = 7; i >= 1; i--) begin
            zero_run    = zero_run & (bus.digits[4*i +: 4] == 4'd0) & ~bus.dp[i];
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign dark = bus.blank[idx_d] | lz_blank[idx_d];

    always_comb begin
        segs_n_d = SEG_OFF;
        dp_n_d   = 1'b1;
        an_n_d   = AN_OFF;
        if (gcnt_d == 8'd0) begin
            an_n_d = ~(8'd1 << idx_d);
            if (!dark) begin
                segs_n_d = seg_pat;
                dp_n_d   = ~bus.dp[idx_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= 3'd0;
            gcnt_q   <= 8'd0;
            segs_n_q <= SEG_OFF;
            dp_n_q   <= 1'b1;
            an_n_q   <= AN_OFF;
        end else begin
            idx_q    <= idx_d;
            gcnt_q   <= gcnt_d;
            segs_n_q <= segs_n_d;
            dp_n_q   <= dp_n_d;
            an_n_q   <= an_n_d;
        end
    end

    assign bus.segs_n = segs_n_q;
    assign bus.dp_n   = dp_n_q;
    assign bus.an_n   = an_n_q;

endmodule
